// File: rtl/ram_responder.sv
// ram_responder: waited big-endian byte-addressed RAM with MFC/MSET handshake
module ram_responder #(
  parameter int DEPTH = 512,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        MSET
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [7:0] mem [DEPTH];
  logic [31:0] a_q, d_q, a, d, ld;
  logic [5:0] op_q, op;
  logic [CW-1:0] cnt;
  logic [32:0] last;
  logic [AW-1:0] ai0, ai1, ai2, ai3;
  logic valid, store, fault, enter_done;
  // Live inputs in IDLE (zero-latency path), latched request afterwards
  always_comb begin
    a = state == IDLE ? Address : a_q;
    d = state == IDLE ? DataIn : d_q;
    op = state == IDLE ? RAM_OpCode : op_q;
    valid = op inside {6'b000000, 6'b000001, 6'b000010, 6'b000100,
                       6'b000101, 6'b000110, 6'b001001, 6'b001010};
    store = op[2];
    last = {1'b0, a} + (op[1:0] == 2'b00 ? 33'd3 : op[1:0] == 2'b10 ? 33'd1 : 33'd0);
    fault = !valid || (op[1:0] == 2'b10 && a[0]) || (op[1:0] == 2'b00 && a[1:0] != 2'b00)
            || last >= 33'(DEPTH);
    ai0 = a[AW-1:0];
    ai1 = ai0 + AW'(1);
    ai2 = ai0 + AW'(2);
    ai3 = ai0 + AW'(3);
    ld = op[1:0] == 2'b00 ? {mem[ai0], mem[ai1], mem[ai2], mem[ai3]} :
         op[1:0] == 2'b01 ? {{24{op[3] & mem[ai0][7]}}, mem[ai0]} :
                            {{16{op[3] & mem[ai0][7]}}, mem[ai0], mem[ai1]};
    enter_done = RAM_enable && (state == IDLE ? LATENCY == 0 : state == WAIT && cnt == CW'(1));
  end
  // State register, wait counter and request capture
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt <= '0;
      a_q <= '0;
      d_q <= '0;
      op_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && RAM_enable) begin
        cnt <= CW'(LATENCY);
        a_q <= Address;
        d_q <= DataIn;
        op_q <= RAM_OpCode;
      end else if (state == WAIT) cnt <= cnt - CW'(1);
    end
  end
  // Next state: four-phase handshake, enable drop in WAIT aborts
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = RAM_enable ? (LATENCY == 0 ? DONE : WAIT) : IDLE;
      WAIT: nxt = !RAM_enable ? IDLE : cnt == CW'(1) ? DONE : WAIT;
      DONE: nxt = RAM_enable ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Handshake outputs follow the DONE state
  always_comb begin
    MFC = state == DONE;
    MSET = state == DONE && fault;
  end
  // Load result captured on the DONE edge, held afterwards
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) DataOut <= '0;
    else if (enter_done && !store && !fault) DataOut <= ld;
  end
  // Store commits atomically on the DONE edge; contents survive reset
  always_ff @(posedge Clk) begin
    if (enter_done && store && !fault) begin
      if (op[1:0] == 2'b00) begin
        mem[ai0] <= d[31:24];
        mem[ai1] <= d[23:16];
        mem[ai2] <= d[15:8];
        mem[ai3] <= d[7:0];
      end else if (op[1:0] == 2'b10) begin
        mem[ai0] <= d[15:8];
        mem[ai1] <= d[7:0];
      end else mem[ai0] <= d[7:0];
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of the RAM responder at LATENCY 2 and 0
module tb_ram_responder;
  localparam logic [5:0] LD = 6'b000000, LDUB = 6'b000001, LDUH = 6'b000010, ST = 6'b000100,
                         STB = 6'b000101, STH = 6'b000110, LDSB = 6'b001001, LDSH = 6'b001010;
  logic Clk = 1'b0;
  logic RESET;
  logic [1:0] en;
  logic [5:0] op;
  logic [31:0] addr, din;
  logic [31:0] dout0, dout1, dout_s;
  logic mfc0, mfc1, mset0, mset1, mfc_s, mset_s, sel;
  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  ram_responder #(.DEPTH(512), .LATENCY(2)) u0 (
    .Clk(Clk), .RESET(RESET), .RAM_enable(en[0]), .RAM_OpCode(op), .Address(addr),
    .DataIn(din), .DataOut(dout0), .MFC(mfc0), .MSET(mset0));
  ram_responder #(.DEPTH(512), .LATENCY(0)) u1 (
    .Clk(Clk), .RESET(RESET), .RAM_enable(en[1]), .RAM_OpCode(op), .Address(addr),
    .DataIn(din), .DataOut(dout1), .MFC(mfc1), .MSET(mset1));

  assign mfc_s = sel ? mfc1 : mfc0;
  assign mset_s = sel ? mset1 : mset0;
  assign dout_s = sel ? dout1 : dout0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full handshake; request fields are scrambled after capture to prove latching
  task automatic access(input string nm, input logic s, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat, input logic exp_f,
                        input logic [31:0] exp_q, input int hold);
    int lat;
    logic [31:0] q;
    @(negedge Clk);
    sel = s;
    op = o;
    addr = a;
    din = d;
    en[s] = 1'b1;
    @(posedge Clk);
    #1;
    addr = ~a;
    din = ~d;
    op = 6'b111111;
    lat = 0;
    while (!mfc_s && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    chk({nm, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "/mset"}, {31'b0, mset_s}, {31'b0, exp_f});
    chk({nm, "/data"}, dout_s, exp_q);
    q = dout_s;
    repeat (hold) begin
      @(posedge Clk);
      #1;
      chk({nm, "/hold_mfc"}, {31'b0, mfc_s}, 32'd1);
      chk({nm, "/hold_data"}, dout_s, q);
    end
    @(negedge Clk);
    en[s] = 1'b0;
    @(posedge Clk);
    #1;
    chk({nm, "/drop"}, {30'b0, mfc_s, mset_s}, 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    en = 2'b00;
    sel = 1'b0;
    op = '0;
    addr = '0;
    din = '0;
    repeat (2) @(negedge Clk);
    chk("reset_u0", {dout0[29:0], mfc0, mset0}, 32'd0);
    chk("reset_u0_data", dout0, 32'd0);
    chk("reset_u1", {dout1[29:0], mfc1, mset1}, 32'd0);
    RESET = 1'b1;
    access("st_word", 0, ST, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 0);
    access("ld_word", 0, LD, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 0);
    access("ldub", 0, LDUB, 32'h10, 32'h0, 2, 0, 32'h000000DE, 0);
    access("ldsb", 0, LDSB, 32'h10, 32'h0, 2, 0, 32'hFFFFFFDE, 0);
    access("lduh", 0, LDUH, 32'h12, 32'h0, 2, 0, 32'h0000BEEF, 0);
    access("ldsh", 0, LDSH, 32'h12, 32'h0, 2, 0, 32'hFFFFBEEF, 0);
    access("stb", 0, STB, 32'h11, 32'hFFFFFF5A, 2, 0, 32'hFFFFBEEF, 0);
    access("ld_after_stb", 0, LD, 32'h10, 32'h0, 2, 0, 32'hDE5ABEEF, 0);
    access("sth", 0, STH, 32'h12, 32'hFFFF1234, 2, 0, 32'hDE5ABEEF, 0);
    access("ld_after_sth", 0, LD, 32'h10, 32'h0, 2, 0, 32'hDE5A1234, 0);
    access("ld_misaligned", 0, LD, 32'h13, 32'h0, 2, 1, 32'hDE5A1234, 0);
    access("lduh_misaligned", 0, LDUH, 32'h11, 32'h0, 2, 1, 32'hDE5A1234, 0);
    access("st_top", 0, ST, 32'd508, 32'h11223344, 2, 0, 32'hDE5A1234, 0);
    access("st_oob", 0, ST, 32'd510, 32'h99887766, 2, 1, 32'hDE5A1234, 0);
    access("ld_top", 0, LD, 32'd508, 32'h0, 2, 0, 32'h11223344, 0);
    access("ldub_oob", 0, LDUB, 32'd512, 32'h0, 2, 1, 32'h11223344, 0);
    access("bad_op", 0, 6'b000011, 32'h0, 32'h0, 2, 1, 32'h11223344, 0);
    access("hold", 0, LD, 32'h10, 32'h0, 2, 0, 32'hDE5A1234, 5);
    access("reraise", 0, LDUB, 32'h13, 32'h0, 2, 0, 32'h00000034, 0);
    // Enable withdrawn during WAIT: no MFC and no write
    @(negedge Clk);
    sel = 1'b0;
    op = ST;
    addr = 32'h10;
    din = 32'hAAAAAAAA;
    en[0] = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    en[0] = 1'b0;
    repeat (4) begin
      @(posedge Clk);
      #1;
      chk("abort_mfc", {31'b0, mfc0}, 32'd0);
    end
    access("ld_after_abort", 0, LD, 32'h10, 32'h0, 2, 0, 32'hDE5A1234, 0);
    // Reset during WAIT: outputs clear at once, store never lands
    access("st_prior", 0, ST, 32'h20, 32'h01020304, 2, 0, 32'hDE5A1234, 0);
    @(negedge Clk);
    op = ST;
    addr = 32'h20;
    din = 32'hCAFEBABE;
    en[0] = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    RESET = 1'b0;
    #1;
    chk("rst_mid_flags", {30'b0, mfc0, mset0}, 32'd0);
    chk("rst_mid_data", dout0, 32'd0);
    en[0] = 1'b0;
    repeat (3) @(negedge Clk);
    RESET = 1'b1;
    access("ld_after_rst", 0, LD, 32'h20, 32'h0, 2, 0, 32'h01020304, 0);
    access("z_st", 1, ST, 32'h40, 32'h55667788, 0, 0, 32'h0, 0);
    access("z_ld", 1, LD, 32'h40, 32'h0, 0, 0, 32'h55667788, 0);
    access("z_ldsb_pos", 1, LDSB, 32'h40, 32'h0, 0, 0, 32'h00000055, 0);
    access("z_ldsb_neg", 1, LDSB, 32'h43, 32'h0, 0, 0, 32'hFFFFFF88, 0);
    access("z_ldsh", 1, LDSH, 32'h42, 32'h0, 0, 0, 32'h00007788, 0);
    access("z_misaligned", 1, LDSH, 32'h41, 32'h0, 0, 1, 32'h00007788, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
